// File: rtl/gol_window.sv
// Streaming 3x3 neighbourhood generator for a Game of Life rule block.
// Cells arrive row-major; each window is edge-masked and registered with its (x, y).
module gol_window #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic                        in_cell,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [2:0]                  q1,
  output logic [2:0]                  q2,
  output logic [2:0]                  q3,
  output logic [$clog2(WIDTH)-1:0]    out_x,
  output logic [$clog2(HEIGHT)-1:0]   out_y,
  output logic                        done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH * HEIGHT);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int TL = 2 * WIDTH + 3;

  localparam logic [CW-1:0] LAST_IN    = CW'(WIDTH * HEIGHT - 1);
  localparam logic [CW-1:0] FIRST_EMIT = CW'(WIDTH + 1);
  localparam logic [FW-1:0] LAST_FL    = FW'(WIDTH);
  localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [TL-2:0]   sr_reg;
  logic [CW-1:0]   in_cnt_reg;
  logic [FW-1:0]   fl_cnt_reg;
  logic [XW-1:0]   wx_reg;
  logic [YW-1:0]   wy_reg;

  logic            clear, shift, shift_bit, emit;
  logic [TL-1:0]   taps;
  logic [2:0][2:0] raw;
  logic [2:0]      col_mask;
  logic [2:0]      q1_next, q2_next, q3_next;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    clear      = 1'b0;
    shift      = 1'b0;
    shift_bit  = 1'b0;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift     = 1'b1;
          shift_bit = in_cell;
          emit      = (in_cnt_reg >= FIRST_EMIT);
          if (in_cnt_reg == LAST_IN) state_next = FLUSH;
        end
      end
      FLUSH: begin
        shift = 1'b1;
        emit  = 1'b1;
        if (fl_cnt_reg == LAST_FL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tap line after the current shift: bit j holds the cell pushed j shifts ago.
  assign taps = {sr_reg, shift_bit};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign raw[gi] = taps[(2 - gi) * WIDTH +: 3];
    end
  endgenerate

  assign col_mask = {wx_reg != '0, 1'b1, wx_reg != X_LAST};
  assign q1_next  = raw[0] & col_mask & {3{wy_reg != '0}};
  assign q2_next  = raw[1] & col_mask;
  assign q3_next  = raw[2] & col_mask & {3{wy_reg != Y_LAST}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg     <= '0;
      in_cnt_reg <= '0;
      fl_cnt_reg <= '0;
      wx_reg     <= '0;
      wy_reg     <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid <= emit;
      done      <= emit && (wx_reg == X_LAST) && (wy_reg == Y_LAST);
      if (clear) begin
        sr_reg     <= '0;
        in_cnt_reg <= '0;
        fl_cnt_reg <= '0;
        wx_reg     <= '0;
        wy_reg     <= '0;
      end else begin
        if (shift) sr_reg <= taps[TL-2:0];
        if (state_reg == LOAD && shift && in_cnt_reg != LAST_IN)
          in_cnt_reg <= in_cnt_reg + 1'b1;
        if (state_reg == FLUSH && fl_cnt_reg != LAST_FL)
          fl_cnt_reg <= fl_cnt_reg + 1'b1;
        if (emit) begin
          q1    <= q1_next;
          q2    <= q2_next;
          q3    <= q3_next;
          out_x <= wx_reg;
          out_y <= wy_reg;
          if (wx_reg == X_LAST) begin
            wx_reg <= '0;
            if (wy_reg != Y_LAST) wy_reg <= wy_reg + 1'b1;
          end else begin
            wx_reg <= wx_reg + 1'b1;
          end
        end
      end
    end
  end

endmodule
